dac_spi_multi: RTL and testbench

- Parametrised multi-channel SPI DAC transmitter; successor to the single-channel DAC output path driving o_DAC_MOSI/o_DAC_SCK/o_DAC_CS from top.
- Accepts one sample vector (all channels) per valid/ready handshake, holds it in a one-deep skid buffer, then serialises one framed SPI write per channel, channel 0 first.
- Sits between the additive oscillator sample pipeline and the external DAC pins.

---
 rtl/dac_pkg.sv | 27 ++
 rtl/dac_spi_multi_if.sv | 15 +
 rtl/spi_frame_tx.sv | 94 +++++++++
 rtl/dac_spi_multi.sv | 142 ++++++++++++++
 tb/tb_dac_spi_multi.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/dac_pkg.sv
// Shared types and constants for the multi-channel SPI DAC transmitter.
// Holds the sequencer state encoding and frame-width derivation.
package dac_pkg;

    localparam logic [3:0] CMD_DEFAULT = 4'b0011;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_GAP,
        ST_NEXT
    } dac_state_e;

    // Frame is {cmd nibble, channel nibble, sample}.
    function automatic int frame_w(input int data_w);
        return 8 + data_w;
    endfunction

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/dac_spi_multi_if.sv
// Link between the channel sequencer and the single-frame SPI shifter.
// The master starts a frame; the slave drives the pins and flags the final bit.
interface dac_spi_multi_if #(
    parameter int FRAME_W = 24
);
    logic               start;
    logic [FRAME_W-1:0] frame;
    logic               done;
    logic               mosi;
    logic               sck;
    logic               cs;

    modport master (output start, frame, input done, mosi, sck, cs);
    modport slave  (input start, frame, output done, mosi, sck, cs);
endinterface

// File: rtl/spi_frame_tx.sv
// Shifts one FRAME_W-bit word out MSB first as SPI mode 0 with CS framing.
// done is high in the last CS-low cycle, so the caller can change state as CS rises.
module spi_frame_tx
    import dac_pkg::*;
#(
    parameter int FRAME_W = 24,
    parameter int SCK_DIV = 2
) (
    input logic            i_Clock,
    input logic            reset_n,
    dac_spi_multi_if.slave fr
);
    localparam int DIV_W = clog2(SCK_DIV + 1);
    localparam int BIT_W = clog2(FRAME_W + 1);
    localparam logic [DIV_W-1:0] DIV_END = DIV_W'(SCK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_END = BIT_W'(FRAME_W - 1);

    logic               active_q, active_d;
    logic               cs_q, cs_d;
    logic               sck_q, sck_d;
    logic               mosi_q, mosi_d;
    logic [FRAME_W-1:0] shift_q, shift_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [BIT_W-1:0]   bit_q, bit_d;

    always_comb begin
        // NOTE: every _d starts from its _q value so no path can infer a latch.
        active_d = active_q;
        cs_d     = cs_q;
        sck_d    = sck_q;
        mosi_d   = mosi_q;
        shift_d  = shift_q;
        div_d    = div_q;
        bit_d    = bit_q;
        fr.done  = 1'b0;

        if (fr.start) begin
            active_d = 1'b1;
            cs_d     = 1'b0;
            sck_d    = 1'b0;
            shift_d  = fr.frame;
            mosi_d   = fr.frame[FRAME_W-1];
            div_d    = '0;
            bit_d    = '0;
        end else if (active_q) begin
            if (div_q == DIV_END) begin
                div_d = '0;
                sck_d = ~sck_q;
                // Falling SCK edge: advance MOSI, or close the frame after the last bit.
                if (sck_q) begin
                    if (bit_q == BIT_END) begin
                        fr.done  = 1'b1;
                        active_d = 1'b0;
                        cs_d     = 1'b1;
                        sck_d    = 1'b0;
                        mosi_d   = 1'b0;
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        shift_d = shift_q << 1;
                        mosi_d  = shift_q[FRAME_W-2];
                    end
                end
            end else begin
                div_d = div_q + 1'b1;
            end
        end
    end

    always_ff @(posedge i_Clock or negedge reset_n) begin
        if (!reset_n) begin
            active_q <= 1'b0;
            cs_q     <= 1'b1;
            sck_q    <= 1'b0;
            mosi_q   <= 1'b0;
            shift_q  <= '0;
            div_q    <= '0;
            bit_q    <= '0;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values.
            active_q <= active_d;
            cs_q     <= cs_d;
            sck_q    <= sck_d;
            mosi_q   <= mosi_d;
            shift_q  <= shift_d;
            div_q    <= div_d;
            bit_q    <= bit_d;
        end
    end

    assign fr.cs   = cs_q;
    assign fr.sck  = sck_q;
    assign fr.mosi = mosi_q;

endmodule

// File: rtl/dac_spi_multi.sv
// Multi-channel SPI DAC transmitter: skid-buffers one sample vector and sends
// one framed write per channel, channel 0 first, with a CS gap between frames.
module dac_spi_multi
    import dac_pkg::*;
#(
    parameter int         NUM_CH  = 2,
    parameter int         DATA_W  = 16,
    parameter logic [3:0] CMD     = CMD_DEFAULT,
    parameter int         SCK_DIV = 2,
    parameter int         CS_GAP  = 4
) (
    input  logic                     i_Clock,
    input  logic                     reset_n,
    input  logic [NUM_CH*DATA_W-1:0] i_Sample,
    input  logic                     i_Sample_Valid,
    output logic                     o_Sample_Ready,
    output logic                     o_DAC_MOSI,
    output logic                     o_DAC_SCK,
    output logic                     o_DAC_CS,
    output logic                     o_Busy,
    output logic                     o_Vector_Done
);
    localparam int FRAME_W = frame_w(DATA_W);
    localparam int VEC_W   = NUM_CH * DATA_W;
    localparam int GAP_W   = clog2(CS_GAP + 1);
    localparam logic [3:0]       LAST_CH = 4'(NUM_CH - 1);
    localparam logic [GAP_W-1:0] GAP_END = GAP_W'(CS_GAP - 1);

    dac_state_e       state_q, state_d;
    logic [VEC_W-1:0] buf_q, buf_d;
    logic [VEC_W-1:0] vec_q, vec_d;
    logic             buf_full_q, buf_full_d;
    logic             ready_q, ready_d;
    logic [3:0]       ch_q, ch_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic             buf_free;
    logic             vec_done;
    logic             handshake;

    dac_spi_multi_if #(.FRAME_W(FRAME_W)) frame_if ();

    spi_frame_tx #(
        .FRAME_W(FRAME_W),
        .SCK_DIV(SCK_DIV)
    ) u_tx (
        .i_Clock(i_Clock),
        .reset_n(reset_n),
        .fr     (frame_if)
    );

    function automatic logic [FRAME_W-1:0] make_frame(input logic [VEC_W-1:0] vec,
                                                      input logic [3:0]       idx);
        return {CMD, idx, vec[int'(idx)*DATA_W +: DATA_W]};
    endfunction

    always_comb begin
        state_d        = state_q;
        buf_d          = buf_q;
        buf_full_d     = buf_full_q;
        vec_d          = vec_q;
        ch_d           = ch_q;
        gap_d          = gap_q;
        buf_free       = 1'b0;
        vec_done       = 1'b0;
        frame_if.start = 1'b0;
        frame_if.frame = '0;
        handshake      = i_Sample_Valid && ready_q;

        case (state_q)
            ST_IDLE: if (buf_full_q) state_d = ST_LOAD;
            ST_LOAD: begin
                vec_d          = buf_q;
                ch_d           = '0;
                buf_free       = 1'b1;
                frame_if.start = 1'b1;
                frame_if.frame = make_frame(buf_q, 4'd0);
                state_d        = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (frame_if.done) begin
                    gap_d   = '0;
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                if (gap_q == GAP_END) state_d = ST_NEXT;
                else gap_d = gap_q + 1'b1;
            end
            ST_NEXT: begin
                if (ch_q < LAST_CH) begin
                    ch_d           = ch_q + 4'd1;
                    frame_if.start = 1'b1;
                    frame_if.frame = make_frame(vec_q, ch_q + 4'd1);
                    state_d        = ST_SHIFT;
                end else begin
                    vec_done = 1'b1;
                    state_d  = buf_full_q ? ST_LOAD : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A capture in the freeing cycle wins, keeping the buffer full.
        if (handshake) begin
            buf_d      = i_Sample;
            buf_full_d = 1'b1;
        end else if (buf_free) begin
            buf_full_d = 1'b0;
        end
        ready_d = !buf_full_d;
    end

    always_ff @(posedge i_Clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            buf_full_q <= 1'b0;
            ready_q    <= 1'b1;
            ch_q       <= '0;
            gap_q      <= '0;
        end else begin
            state_q    <= state_d;
            buf_full_q <= buf_full_d;
            ready_q    <= ready_d;
            ch_q       <= ch_d;
            gap_q      <= gap_d;
        end
    end

    // NOTE: sample storage has no reset; buf_full_q and the FSM gate every use of it.
    always_ff @(posedge i_Clock) begin
        buf_q <= buf_d;
        vec_q <= vec_d;
    end

    assign o_Sample_Ready = ready_q;
    assign o_Busy         = (state_q != ST_IDLE);
    assign o_Vector_Done  = vec_done;
    assign o_DAC_MOSI     = frame_if.mosi;
    assign o_DAC_SCK      = frame_if.sck;
    assign o_DAC_CS       = frame_if.cs;

endmodule

// File: tb/tb_dac_spi_multi.sv
// Scoreboard bench for dac_spi_multi: a default instance and a 4x12-bit, fast-clock instance.
// Frames are decoded from the pins and compared with frames built from the sample rules.
module tb_dac_spi_multi;

    logic        clk = 1'b0;
    logic [1:0]  rst_n = 2'b00;
    logic [1:0]  vld = 2'b00;
    logic [31:0] smp0 = '0;
    logic [47:0] smp1 = '0;
    logic [1:0]  rdy, mosi, sck, cs, busy, done;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] exp0[$];
    logic [31:0] exp1[$];

    // Monitor state, one slot per instance
    int          low_cnt[2]   = '{0, 0};
    int          gap_cnt[2]   = '{0, 0};
    int          nbits[2]     = '{0, 0};
    int          frames[2]    = '{0, 0};
    int          sck_rises[2] = '{0, 0};
    logic [31:0] shreg[2]     = '{0, 0};
    bit          have_prev[2] = '{0, 0};
    bit          gap_done[2]  = '{0, 0};
    bit          gap_idle[2]  = '{0, 0};
    bit          idle_bad[2]  = '{0, 0};
    bit          prev_cs[2]   = '{1, 1};
    bit          prev_sck[2]  = '{0, 0};
    bit          prev_done[2] = '{0, 0};

    always #5 clk = ~clk;

    dac_spi_multi dut0 (
        .i_Clock(clk), .reset_n(rst_n[0]), .i_Sample(smp0), .i_Sample_Valid(vld[0]),
        .o_Sample_Ready(rdy[0]), .o_DAC_MOSI(mosi[0]), .o_DAC_SCK(sck[0]),
        .o_DAC_CS(cs[0]), .o_Busy(busy[0]), .o_Vector_Done(done[0])
    );

    dac_spi_multi #(.NUM_CH(4), .DATA_W(12), .SCK_DIV(1), .CS_GAP(1)) dut1 (
        .i_Clock(clk), .reset_n(rst_n[1]), .i_Sample(smp1), .i_Sample_Valid(vld[1]),
        .o_Sample_Ready(rdy[1]), .o_DAC_MOSI(mosi[1]), .o_DAC_SCK(sck[1]),
        .o_DAC_CS(cs[1]), .o_Busy(busy[1]), .o_Vector_Done(done[1])
    );

    function automatic int p_n(input int k);  return (k == 0) ? 2 : 4;  endfunction
    function automatic int p_d(input int k);  return (k == 0) ? 16 : 12; endfunction
    function automatic int p_s(input int k);  return (k == 0) ? 2 : 1;  endfunction
    function automatic int p_g(input int k);  return (k == 0) ? 4 : 1;  endfunction
    function automatic int p_fw(input int k); return p_d(k) + 8;        endfunction

    // Reference frame: command 3, channel number, then that channel's sample.
    function automatic logic [31:0] ref_frame(input int k, input logic [63:0] v, input int ch);
        logic [63:0] mask;
        logic [63:0] f;
        mask = (64'd1 << p_d(k)) - 64'd1;
        f = (64'd3 << (p_d(k) + 4)) | (64'(ch) << p_d(k)) | ((v >> (ch * p_d(k))) & mask);
        return f[31:0];
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Pin monitor: decodes frames, checks timing and pops the scoreboard.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if (!rst_n[k]) begin
                    have_prev[k] = 0; frames[k] = 0; nbits[k] = 0; idle_bad[k] = 0;
                    prev_cs[k] = 1; prev_sck[k] = 0; prev_done[k] = 0;
                end else begin
                    if (sck[k] && !prev_sck[k]) sck_rises[k]++;
                    if (!cs[k]) begin
                        if (prev_cs[k]) begin
                            if (have_prev[k]) begin
                                if (gap_idle[k]) check("gap_min", longint'(gap_cnt[k] >= p_g(k)), 1);
                                else if (gap_done[k]) check("gap_b2b", gap_cnt[k], p_g(k) + 2);
                                else check("gap_in_vec", gap_cnt[k], p_g(k) + 1);
                                check("idle_pins", idle_bad[k], 0);
                            end
                            nbits[k] = 0; low_cnt[k] = 0; shreg[k] = '0;
                        end
                        low_cnt[k]++;
                        if (sck[k] && !prev_sck[k]) begin
                            shreg[k] = {shreg[k][30:0], mosi[k]};
                            nbits[k]++;
                        end
                    end else begin
                        if (!prev_cs[k]) begin
                            check("cs_low_len", low_cnt[k], 2 * p_s(k) * p_fw(k));
                            check("frame_bits", nbits[k], p_fw(k));
                            if (k == 0 && exp0.size() > 0) begin
                                e = exp0.pop_front(); check("frame_data0", shreg[k], e);
                            end else if (k == 1 && exp1.size() > 0) begin
                                e = exp1.pop_front(); check("frame_data1", shreg[k], e);
                            end else begin
                                check("unexpected_frame", shreg[k], -1);
                            end
                            frames[k]++;
                            have_prev[k] = 1; gap_cnt[k] = 0;
                            gap_done[k] = 0; gap_idle[k] = 0; idle_bad[k] = 0;
                        end
                        gap_cnt[k]++;
                        if (sck[k] || mosi[k]) idle_bad[k] = 1;
                        if (done[k]) gap_done[k] = 1;
                        if (!busy[k]) gap_idle[k] = 1;
                    end
                    if (done[k]) begin
                        check("done_frames", frames[k], p_n(k));
                        check("done_one_cycle", prev_done[k], 0);
                        frames[k] = 0;
                    end
                    prev_cs[k] = cs[k]; prev_sck[k] = sck[k]; prev_done[k] = done[k];
                end
            end
        end
    end

    // Present a vector, hold it until accepted, then push its expected frames.
    task automatic send(input int k, input logic [63:0] v);
        int waited;
        waited = 0;
        @(negedge clk);
        if (k == 0) smp0 = v[31:0]; else smp1 = v[47:0];
        vld[k] = 1'b1;
        while (!rdy[k] && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        if (!rdy[k]) begin
            check("send_timeout", 0, 1);
            vld[k] = 1'b0;
        end else begin
            for (int ch = 0; ch < p_n(k); ch++) begin
                if (k == 0) exp0.push_back(ref_frame(k, v, ch));
                else exp1.push_back(ref_frame(k, v, ch));
            end
            @(negedge clk);
            vld[k] = 1'b0;
            check("ready_drop", rdy[k], 0);
        end
    endtask

    task automatic wait_drain(input int k);
        int waited;
        int left;
        waited = 0;
        left = (k == 0) ? exp0.size() : exp1.size();
        while ((left > 0 || busy[k]) && waited < 5000) begin
            @(negedge clk);
            waited++;
            left = (k == 0) ? exp0.size() : exp1.size();
        end
        check("drain_left", left, 0);
        check("drain_busy", busy[k], 0);
        check("drain_ready", rdy[k], 1);
        check("drain_cs", cs[k], 1);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int waited;
        logic [63:0] v;

        #500;
        for (int k = 0; k < 2; k++) begin
            check("rst_cs", cs[k], 1);
            check("rst_sck", sck[k], 0);
            check("rst_mosi", mosi[k], 0);
            check("rst_ready", rdy[k], 1);
            check("rst_busy", busy[k], 0);
            check("rst_done", done[k], 0);
        end
        #500;
        @(negedge clk);
        rst_n = 2'b11;
        repeat (20) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check("idle_cs", cs[k], 1);
            check("idle_busy", busy[k], 0);
            check("idle_ready", rdy[k], 1);
            check("idle_no_sck", sck_rises[k], 0);
        end

        // Single vector
        send(0, 64'hBEEF_1234);
        wait_drain(0);

        // Back-to-back vectors; later sends wait on backpressure
        for (int i = 0; i < 4; i++) send(0, {32'd0, $urandom});
        wait_drain(0);

        // Asynchronous reset in the middle of frame 0
        send(0, {32'd0, $urandom});
        waited = 0;
        while (!(nbits[0] == 10 && !cs[0]) && waited < 500) begin
            @(negedge clk);
            waited++;
        end
        check("reach_bit10", nbits[0], 10);
        #2;
        rst_n[0] = 1'b0;
        exp0.delete();
        #1;
        check("async_cs", cs[0], 1);
        check("async_sck", sck[0], 0);
        check("async_mosi", mosi[0], 0);
        check("async_busy", busy[0], 0);
        check("async_ready", rdy[0], 1);
        repeat (5) @(negedge clk);
        rst_n[0] = 1'b1;
        send(0, 64'h0001_8000);
        wait_drain(0);

        // Four channels, 12-bit samples, fastest SCK and shortest gap
        send(1, 64'h0000_ABC1_2345_6789);
        for (int i = 0; i < 3; i++) begin
            v = {$urandom, $urandom};
            send(1, v);
        end
        wait_drain(1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
